// File: rtl/fifo_sync_param_pkg.sv
// Shared definitions for the parametrised synchronous FIFO: read-mode encodings and a
// constant-foldable log2 helper used for parameter legality checks.
package fifo_defs;

  localparam int unsigned RD_MODE_FWFT = 0;
  localparam int unsigned RD_MODE_REG  = 1;

  // Smallest r such that 2**r >= v.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_sync_param_mem.sv
// Register-array storage for the FIFO: one synchronous write port, one asynchronous read port.
// Not reset; contents are only meaningful behind the FIFO pointers.
module fifo_mem_1w1r #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 16,
  parameter int unsigned Aw    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [Aw-1:0]    waddr_i,
  input  logic [Width-1:0] wdata_i,
  input  logic [Aw-1:0]    raddr_i,
  output logic [Width-1:0] rdata_o
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised SIMD FIFO with occupancy count, programmable almost flags,
// synchronous flush, sticky overflow/underflow and show-ahead or registered read output.
module fifo_sync_param
  import fifo_defs::*;
#(
  parameter int unsigned bw      = 4,
  parameter int unsigned simd    = 1,
  parameter int unsigned depth   = 16,
  parameter int unsigned aw      = 4,
  parameter int unsigned af_lvl  = 12,
  parameter int unsigned ae_lvl  = 2,
  parameter int unsigned rd_mode = RD_MODE_FWFT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               wr,
  input  logic [simd*bw-1:0] in,
  input  logic               rd,
  output logic [simd*bw-1:0] out,
  output logic               o_full,
  output logic               o_empty,
  output logic               o_almost_full,
  output logic               o_almost_empty,
  output logic [aw:0]        o_count,
  output logic               o_valid,
  output logic               o_overflow,
  output logic               o_underflow
);

  localparam int unsigned W = simd * bw;
  localparam logic [aw:0] AfLvl = (aw + 1)'(af_lvl);
  localparam logic [aw:0] AeLvl = (aw + 1)'(ae_lvl);

  if (depth < 2 || depth != (32'd1 << aw) || aw != clog2(depth) || ae_lvl >= af_lvl ||
      af_lvl > depth || rd_mode > RD_MODE_REG) begin : g_bad_param
    $error("fifo_sync_param: illegal parameter set");
  end

  logic [aw:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic         full, empty, rd_acc, wr_acc;
  logic [W-1:0] rdata;

  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full   = (wr_ptr_q[aw-1:0] == rd_ptr_q[aw-1:0]) && (wr_ptr_q[aw] != rd_ptr_q[aw]);
  assign rd_acc = rd && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
  assign wr_acc = wr && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      if (wr && full && !rd_acc) ovf_d = 1'b1;
      if (rd && empty) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem_1w1r #(
    .Width (W),
    .Depth (depth),
    .Aw    (aw)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (wr_acc && !flush),
    .waddr_i (wr_ptr_q[aw-1:0]),
    .wdata_i (in),
    .raddr_i (rd_ptr_q[aw-1:0]),
    .rdata_o (rdata)
  );

  assign o_count        = wr_ptr_q - rd_ptr_q;
  assign o_full         = full;
  assign o_empty        = empty;
  assign o_almost_full  = (o_count >= AfLvl);
  assign o_almost_empty = (o_count <= AeLvl);
  assign o_overflow     = ovf_q;
  assign o_underflow    = unf_q;

  if (rd_mode == RD_MODE_REG) begin : g_reg_out
    logic [W-1:0] out_q;
    logic         valid_q;

    // out holds its last popped value; only o_valid marks freshness.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        out_q   <= '0;
        valid_q <= 1'b0;
      end else if (flush) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) out_q <= rdata;
      end
    end

    assign out     = out_q;
    assign o_valid = valid_q;
  end else begin : g_fwft_out
    assign out     = rdata;
    assign o_valid = !empty;
  end

endmodule
